// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan path.
//   - Active-low cathode patterns (bit7=a ... bit1=g, bit0=dp) for codes 0-9
//     and the dp-only pattern. The encoder side uses the same table.
//   - Special codes for the dp-only digit and undecodable patterns.
//   - Capture FSM state type.
package seg7_pkg;

  localparam logic [7:0] SEG_0  = 8'b0000_0011;
  localparam logic [7:0] SEG_1  = 8'b1001_1111;
  localparam logic [7:0] SEG_2  = 8'b0010_0101;
  localparam logic [7:0] SEG_3  = 8'b0000_1101;
  localparam logic [7:0] SEG_4  = 8'b1001_1001;
  localparam logic [7:0] SEG_5  = 8'b0100_1001;
  localparam logic [7:0] SEG_6  = 8'b0100_0001;
  localparam logic [7:0] SEG_7  = 8'b0001_1111;
  localparam logic [7:0] SEG_8  = 8'b0000_0001;
  localparam logic [7:0] SEG_9  = 8'b0000_1001;
  localparam logic [7:0] SEG_DP = 8'b1111_1110;

  localparam logic [3:0] CODE_DP  = 4'hA;
  localparam logic [3:0] CODE_ERR = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational cathode pattern -> 4-bit code.
// Optional macro: SEG7_DP_DECODE_EN
//   undefined: exact 8-bit match; a digit with dp lit is an error.
//   defined:   digits 0-9 match on segments a..g only, dp is ignored.
//              The dp-only pattern still decodes to CODE_DP.
// Ports:
//   cathode  in  [7:0]  active-low segment pattern
//   code     out [3:0]  decoded code, CODE_ERR when not in the table
//   err      out        high when the pattern is not in the table
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] cathode,
  output logic [3:0] code,
  output logic       err
);

  logic [7:0] key;

  always_comb begin
    key = cathode;
`ifdef SEG7_DP_DECODE_EN
    // Force dp to "unlit" so digits match with either dp state; the
    // dp-only pattern is left intact so it still reaches its own entry.
    if (cathode != SEG_DP) key[0] = 1'b1;
`endif
    code = CODE_ERR;
    err  = 1'b0;
    case (key)
      SEG_0:   code = 4'd0;
      SEG_1:   code = 4'd1;
      SEG_2:   code = 4'd2;
      SEG_3:   code = 4'd3;
      SEG_4:   code = 4'd4;
      SEG_5:   code = 4'd5;
      SEG_6:   code = 4'd6;
      SEG_7:   code = 4'd7;
      SEG_8:   code = 4'd8;
      SEG_9:   code = 4'd9;
      SEG_DP:  code = CODE_DP;
      default: begin
        code = CODE_ERR;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 7-segment bus and rebuilds the
// displayed frame of NUM_DIGITS 4-bit codes.
// Optional macro: SEG7_DP_DECODE_EN (dp-tolerant decode, adds dp_out).
// Parameters:
//   NUM_DIGITS     number of anodes scanned
//   SETTLE_CYCLES  identical samples needed before a digit is accepted (2..255)
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   anode         in   [NUM_DIGITS-1:0] active-low digit enables
//   cathode       in   [7:0] active-low segments (bit7=a .. bit1=g, bit0=dp)
//   clear         in   aborts the frame in progress
//   frame_out     out  [4*NUM_DIGITS-1:0] last complete frame, digit i at [4i+3:4i]
//   frame_done    out  one-cycle pulse when frame_out updates
//   capture_mask  out  [NUM_DIGITS-1:0] digits captured in the current frame
//   pattern_err   out  one-cycle pulse when a captured pattern is not decodable
//   dp_out        out  [NUM_DIGITS-1:0] dp lit per digit (macro builds only)
//
// state  | meaning
// IDLE   | registered anode not one-cold, nothing selected
// SETTLE | one digit selected, counting identical samples
// HOLD   | digit captured (or frame cleared), waiting for the bus to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [7:0]              cathode,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] frame_out,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   capture_mask,
  output logic                    pattern_err
`ifdef SEG7_DP_DECODE_EN
  ,
  output logic [NUM_DIGITS-1:0]   dp_out
`endif
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] CNT_TC = 8'(SETTLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   anode_q, anode_p;
  logic [7:0]              cathode_q, cathode_p;
  state_t                  state;
  logic [7:0]              cnt;
  logic [3:0]              digit_q [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] frame_next;
  logic [IDXW-1:0]         sel;
  logic                    one_cold;
  logic                    same;
  logic [3:0]              dec_code;
  logic                    dec_err;
`ifdef SEG7_DP_DECODE_EN
  logic [NUM_DIGITS-1:0]   dp_q;
`endif

  assign one_cold = $onehot(~anode_q);
  assign same     = (anode_q == anode_p) && (cathode_q == cathode_p);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anode_q[i]) sel = IDXW'(i);
    end
  end

  always_comb begin
    frame_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      frame_next[4*i +: 4] = digit_q[i];
    end
  end

  seg7_pattern_decode u_decode (
    .cathode (cathode_q),
    .code    (dec_code),
    .err     (dec_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_q      <= '1;
      anode_p      <= '1;
      cathode_q    <= '1;
      cathode_p    <= '1;
      state        <= IDLE;
      cnt          <= '0;
      frame_out    <= '0;
      frame_done   <= 1'b0;
      capture_mask <= '0;
      pattern_err  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
`ifdef SEG7_DP_DECODE_EN
      dp_q         <= '0;
      dp_out       <= '0;
`endif
    end else begin
      anode_q     <= anode;
      cathode_q   <= cathode;
      anode_p     <= anode_q;
      cathode_p   <= cathode_q;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;

      if (clear) begin
        // Abort wins over both frame completion and a same-cycle capture.
        capture_mask <= '0;
        state        <= HOLD;
        cnt          <= '0;
      end else begin
        // Mask went full on the previous edge: publish the frame.
        if (&capture_mask) begin
          frame_out    <= frame_next;
          frame_done   <= 1'b1;
          capture_mask <= '0;
`ifdef SEG7_DP_DECODE_EN
          dp_out       <= dp_q;
`endif
        end

        case (state)
          IDLE: begin
            if (one_cold) begin
              state <= SETTLE;
              cnt   <= 8'd1;
            end
          end
          SETTLE: begin
            if (!one_cold) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (!same) begin
              cnt <= 8'd1;
            end else if (cnt == CNT_TC) begin
              digit_q[sel]      <= dec_code;
              capture_mask[sel] <= 1'b1;
              pattern_err       <= dec_err;
`ifdef SEG7_DP_DECODE_EN
              dp_q[sel]         <= ~cathode_q[0];
`endif
              cnt               <= cnt + 8'd1;
              state             <= HOLD;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          HOLD: begin
            if (!same) begin
              if (one_cold) begin
                state <= SETTLE;
                cnt   <= 8'd1;
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Testbench for seg7_scan_capture: decode table vectors, directed
// sequences for settle/ghost/clear/reset corners, and a randomized bus
// compared every cycle against a run-length reference model.
module tb_seg7_scan_capture;

  localparam int ND = 8;
  localparam int S  = 4;
`ifdef SEG7_DP_DECODE_EN
  localparam bit DPM = 1'b1;
`else
  localparam bit DPM = 1'b0;
`endif

  // Display patterns for codes 0..9 and the dp-only pattern (index 10).
  localparam logic [7:0] PAT [11] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                      8'h49, 8'h41, 8'h1F, 8'h01, 8'h09,
                                      8'hFE};

  logic            clk = 1'b0;
  logic            reset, clear;
  logic [ND-1:0]   anode;
  logic [7:0]      cathode;
  logic [4*ND-1:0] frame_out;
  logic            frame_done, pattern_err;
  logic [ND-1:0]   capture_mask;
`ifdef SEG7_DP_DECODE_EN
  logic [ND-1:0]   dp_out;
`endif

  seg7_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .anode        (anode),
    .cathode      (cathode),
    .clear        (clear),
    .frame_out    (frame_out),
    .frame_done   (frame_done),
    .capture_mask (capture_mask),
    .pattern_err  (pattern_err)
`ifdef SEG7_DP_DECODE_EN
    ,
    .dp_out       (dp_out)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, done_cnt = 0, err_cnt = 0;

  // Reference model: a digit is accepted one edge after its (anode,cathode)
  // sample has repeated S times in a row, once per run; clear blocks the run
  // sampled before it; a full mask publishes the frame on the following edge.
  logic [ND-1:0]   m_la;
  logic [7:0]      m_lc;
  int              m_rl;
  bit              m_blk;
  logic [3:0]      m_dig [ND];
  logic [4*ND-1:0] m_frame;
  logic            m_done, m_err;
  logic [ND-1:0]   m_mask, m_dp, m_dpout;
  logic [3:0]      mc;
  bit              me;
  int              midx;

  function automatic void ref_decode(input logic [7:0] c, output logic [3:0] code,
                                     output bit err);
    logic [7:0] p;
    code = 4'hF;
    err  = 1'b1;
    if (c == 8'hFE) begin
      code = 4'hA;
      err  = 1'b0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        p = PAT[i];
        if (DPM ? (c[7:1] == p[7:1]) : (c == p)) begin
          code = 4'(i);
          err  = 1'b0;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_la = '1; m_lc = 8'hFF; m_rl = 0; m_blk = 1'b0;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
      m_frame = '0; m_done = 1'b0; m_err = 1'b0;
      m_mask = '0; m_dp = '0; m_dpout = '0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (!clear && m_mask == '1) begin
        for (int i = 0; i < ND; i++) m_frame[4*i +: 4] = m_dig[i];
        m_dpout = m_dp;
        m_done  = 1'b1;
        m_mask  = '0;
      end
      if (!clear && $countones(~m_la) == 1 && !m_blk && m_rl == S) begin
        midx = 0;
        for (int i = 0; i < ND; i++) if (!m_la[i]) midx = i;
        ref_decode(m_lc, mc, me);
        m_dig[midx]  = mc;
        m_mask[midx] = 1'b1;
        m_dp[midx]   = ~m_lc[0];
        m_err        = me;
        m_blk        = 1'b1;
      end
      if (clear) begin
        m_mask = '0;
        m_blk  = 1'b1;
      end
      if (anode == m_la && cathode == m_lc) begin
        if (m_rl < 1000) m_rl++;
      end else begin
        m_rl  = 1;
        m_blk = 1'b0;
      end
      m_la = anode;
      m_lc = cathode;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (frame_done === 1'b1) done_cnt++;
    if (pattern_err === 1'b1) err_cnt++;
`ifdef SEG7_DP_DECODE_EN
    check("cycle", 64'({dp_out, frame_out, frame_done, capture_mask, pattern_err}),
          64'({m_dpout, m_frame, m_done, m_mask, m_err}));
`else
    check("cycle", 64'({frame_out, frame_done, capture_mask, pattern_err}),
          64'({m_frame, m_done, m_mask, m_err}));
`endif
  endtask

  task automatic show(input int d, input logic [7:0] c, input int n);
    anode   = ~(ND'(1) << d);
    cathode = c;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    anode   = '1;
    cathode = 8'hFF;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [7:0] cat;
    logic [3:0] code;
    bit         err;
  } vec_t;

  vec_t            vt [16];
  logic [4*ND-1:0] exp_frame;
  int              d0, e0, r, hold;
  logic [7:0]      save;

  initial begin
    vt[0]  = '{8'h03, 4'h0, 1'b0};
    vt[1]  = '{8'h9F, 4'h1, 1'b0};
    vt[2]  = '{8'h25, 4'h2, 1'b0};
    vt[3]  = '{8'h0D, 4'h3, 1'b0};
    vt[4]  = '{8'h99, 4'h4, 1'b0};
    vt[5]  = '{8'h49, 4'h5, 1'b0};
    vt[6]  = '{8'h41, 4'h6, 1'b0};
    vt[7]  = '{8'h1F, 4'h7, 1'b0};
    vt[8]  = '{8'h01, 4'h8, 1'b0};
    vt[9]  = '{8'h09, 4'h9, 1'b0};
    vt[10] = '{8'hFE, 4'hA, 1'b0};
    vt[11] = '{8'hFF, 4'hF, 1'b1};
    vt[12] = '{8'h02, DPM ? 4'h0 : 4'hF, !DPM};
    vt[13] = '{8'h08, DPM ? 4'h9 : 4'hF, !DPM};
    vt[14] = '{8'h00, DPM ? 4'h8 : 4'hF, !DPM};
    vt[15] = '{8'h55, 4'hF, 1'b1};

    reset = 1'b1; clear = 1'b0; anode = '1; cathode = 8'hFF;
    repeat (3) tick();
    check("reset", 64'({frame_out, frame_done, capture_mask, pattern_err}), 64'(0));
    reset = 1'b0;
    blank(2);

    // Decode table, two frames of eight digits.
    exp_frame = '0;
    for (int k = 0; k < 16; k++) begin
      e0 = err_cnt;
      show(k % 8, vt[k].cat, 8);
      check("vec_err", 64'(err_cnt - e0), 64'(vt[k].err));
      exp_frame[4*(k%8) +: 4] = vt[k].code;
      if (k % 8 == 7) check("vec_frame", 64'(frame_out), 64'(exp_frame));
    end

    // Codes 1..8 on digits 0..7, 10 cycles each.
    blank(2);
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) show(i, PAT[i+1], 10);
    check("plan_done", 64'(done_cnt - d0), 64'(1));
    check("plan_frame", 64'(frame_out), 64'h8765_4321);

    // Settle boundary on digit 2.
    blank(3);
    show(2, 8'h49, S - 1);
    blank(3);
    check("short_hold_mask", 64'(capture_mask), 64'(0));
    show(2, 8'h49, S);
    blank(2);
    check("settle_mask", 64'(capture_mask), 64'h04);

    // Blank pattern on digit 0 held long: one error pulse only.
    e0 = err_cnt;
    show(0, 8'hFF, 10);
    check("ghost_err", 64'(err_cnt - e0), 64'(1));

    // Two anodes low: nothing captured.
    anode = 8'b1111_0011; cathode = 8'h49;
    repeat (20) tick();
    check("two_low_mask", 64'(capture_mask), 64'h05);

    // Five captures, clear, then a full frame; digits 5..7 first so a
    // surviving mask would complete early.
    for (int i = 0; i < 5; i++) show(i, PAT[i], 6);
    anode = '1; cathode = 8'hFF; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_mask", 64'(capture_mask), 64'(0));
    d0 = done_cnt;
    for (int i = 5; i < 8; i++) show(i, PAT[i], 6);
    check("clear_early_done", 64'(done_cnt - d0), 64'(0));
    for (int i = 0; i < 5; i++) show(i, PAT[9-i], 6);
    blank(2);
    check("clear_frame_done", 64'(done_cnt - d0), 64'(1));

    // Same with reset.
    for (int i = 0; i < 5; i++) show(i, PAT[i], 6);
    reset = 1'b1;
    blank(2);
    reset = 1'b0;
    check("reset_frame_out", 64'(frame_out), 64'(0));
    check("reset_mask", 64'(capture_mask), 64'(0));
    d0 = done_cnt;
    for (int i = 5; i < 8; i++) show(i, PAT[i], 6);
    check("reset_early_done", 64'(done_cnt - d0), 64'(0));
    for (int i = 0; i < 5; i++) show(i, PAT[i], 6);
    blank(2);
    check("reset_frame_done", 64'(done_cnt - d0), 64'(1));

    // Digit 9 with dp lit on digit 3.
    e0 = err_cnt;
    show(3, 8'h08, 10);
    check("dp_err", 64'(err_cnt - e0), 64'(!DPM));
    for (int i = 0; i < 8; i++) if (i != 3) show(i, PAT[i], 6);
    blank(2);
    check("dp_code", 64'(frame_out[15:12]), DPM ? 64'h9 : 64'hF);
`ifdef SEG7_DP_DECODE_EN
    check("dp_out", 64'(dp_out), 64'h08);
`endif

    // Randomized bus with glitches, clears and resets.
    for (int seg = 0; seg < 700; seg++) begin
      r = int'($urandom_range(99));
      if (r < 70)      anode = ~(ND'(1) << $urandom_range(ND - 1));
      else if (r < 85) anode = '1;
      else             anode = ND'($urandom);
      cathode = ($urandom_range(3) != 0) ? PAT[$urandom_range(10)] : 8'($urandom);
      hold = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        save = cathode;
        if ($urandom_range(99) < 5) cathode = save ^ (8'(1) << $urandom_range(7));
        if ($urandom_range(99) < 3) clear = 1'b1;
        if ($urandom_range(199) == 0) reset = 1'b1;
        tick();
        cathode = save;
        clear   = 1'b0;
        reset   = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
